// File: rtl/uart_echo_tester_if.sv
// Control/status bundle of the UART echo tester.
// Master starts runs; slave reports progress and results.
interface uart_echo_tester_if;
  logic       start;
  logic [7:0] seed;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] last_sent;
  logic [7:0] last_rcvd;

  modport master (
    output start, seed, count,
    input  busy, done, pass, err_cnt, last_sent, last_rcvd
  );

  modport slave (
    input  start, seed, count,
    output busy, done, pass, err_cnt, last_sent, last_rcvd
  );
endinterface

// File: rtl/uart_echo_tester.sv
// Host-side 8N1 echo tester: sends incrementing frames, checks echoes.
// UART_ECHO_INC_EN: expect echo = sent+1 (else echo = sent).
module uart_echo_tester #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic tx,
  uart_echo_tester_if.slave bus
);
  localparam int TW  = $clog2(DVSR);
  localparam int SW  = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int NW  = $clog2(DBIT > 1 ? DBIT : 2);
  localparam int TOW = $clog2(TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, WAIT_RX,
    RX_START, RX_DATA, RX_STOP, CHECK, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              rx_s1_q, rx_s2_q;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [7:0]        err_q, err_d;
  logic [7:0]        ls_q, ls_d;
  logic [7:0]        lr_q, lr_d;
  logic [7:0]        cur_q, cur_d;
  logic [7:0]        rem_q, rem_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   b_q, b_d;
  logic [DBIT-1:0]   rb_q, rb_d;
  logic [TOW-1:0]    to_q, to_d;
  logic              sup_q, sup_d;
  logic              s_tick;
  logic              rx_s;
  logic [7:0]        exp_b;
  logic [7:0]        nxt_cur;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Free-running oversample tick divider.
  always_comb begin
    s_tick = (tick_q == TW'(DVSR - 1));
    tick_d = s_tick ? '0 : tick_q + TW'(1);
  end

  // Frame sequencer: serializer, deserializer, checker.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    ls_d    = ls_q;
    lr_d    = lr_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    rb_d    = rb_q;
    to_d    = to_q;
    sup_d   = sup_q;
    rx_s    = rx_s2_q;
    nxt_cur = cur_q + 8'd1;
`ifdef UART_ECHO_INC_EN
    exp_b   = cur_q + 8'd1;
`else
    exp_b   = cur_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start) begin
        cur_d  = bus.seed;
        rem_d  = bus.count;
        err_d  = '0;
        done_d = 1'b0;
        busy_d = 1'b1;
        if (bus.count == 8'd0) begin
          state_d = DONE;
        end else begin
          state_d = TX_START;
          ls_d    = bus.seed;
          b_d     = DBIT'(bus.seed);
          tx_d    = 1'b0;
          s_d     = '0;
        end
      end
      TX_START: if (s_tick) begin
        if (s_q == SW'(15)) begin
          s_d     = '0;
          n_d     = '0;
          tx_d    = b_q[0];
          state_d = TX_DATA;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      TX_DATA: if (s_tick) begin
        if (s_q == SW'(15)) begin
          s_d = '0;
          b_d = b_q >> 1;
          if (n_q == NW'(DBIT - 1)) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            n_d  = n_q + NW'(1);
            tx_d = b_q[1];
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      TX_STOP: if (s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          s_d     = '0;
          to_d    = '0;
          sup_d   = 1'b0;
          state_d = WAIT_RX;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      WAIT_RX: begin
        to_d = to_q + TOW'(1);
        if (!rx_s) begin
          s_d     = '0;
          state_d = RX_START;
        end else if (to_q == TOW'(TIMEOUT - 1)) begin
          rb_d    = '0;
          lr_d    = '0;
          err_d   = sat_inc(err_q);
          sup_d   = 1'b1;
          state_d = CHECK;
        end
      end
      RX_START: if (s_tick) begin
        if (s_q == SW'(7)) begin
          s_d = '0;
          n_d = '0;
          state_d = rx_s ? WAIT_RX : RX_DATA;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      RX_DATA: if (s_tick) begin
        if (s_q == SW'(15)) begin
          s_d  = '0;
          rb_d = {rx_s, rb_q[DBIT-1:1]};
          if (n_q == NW'(DBIT - 1)) begin
            state_d = RX_STOP;
          end else begin
            n_d = n_q + NW'(1);
          end
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      RX_STOP: if (s_tick) begin
        if (s_q == SW'(SB_TICK - 1)) begin
          s_d = '0;
          if (!rx_s) begin
            err_d = sat_inc(err_q);
            sup_d = 1'b1;
          end
          state_d = CHECK;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      CHECK: begin
        lr_d = 8'(rb_q);
        if (!sup_q && (8'(rb_q) != exp_b)) begin
          err_d = sat_inc(err_q);
        end
        cur_d = nxt_cur;
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) begin
          state_d = DONE;
        end else begin
          state_d = TX_START;
          ls_d    = nxt_cur;
          b_d     = DBIT'(nxt_cur);
          tx_d    = 1'b0;
          s_d     = '0;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == 8'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ls_q    <= '0;
      lr_q    <= '0;
      cur_q   <= '0;
      rem_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      rb_q    <= '0;
      to_q    <= '0;
      sup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ls_q    <= ls_d;
      lr_q    <= lr_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      rb_q    <= rb_d;
      to_q    <= to_d;
      sup_q   <= sup_d;
    end
  end

  assign tx            = tx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_q;
  assign bus.last_sent = ls_q;
  assign bus.last_rcvd = lr_q;
endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: serial echo model plus run table.
// Echo offset follows UART_ECHO_INC_EN like the design.
module tb_uart_echo_tester;
`ifdef UART_ECHO_INC_EN
  localparam logic [7:0] INC = 8'd1;
`else
  localparam logic [7:0] INC = 8'd0;
`endif
  localparam logic [2:0] M_OK  = 3'd0;
  localparam logic [2:0] M_FIX = 3'd1;
  localparam logic [2:0] M_SIL = 3'd2;
  localparam logic [2:0] M_BAD = 3'd3;
  localparam logic [2:0] M_GL  = 3'd4;

  typedef struct {
    logic [2:0] mode;
    logic [7:0] seed;
    logic [7:0] cnt;
    logic [7:0] err;
    logic       pass;
    logic [7:0] ls;
    logic [7:0] lr;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       stopv;
    logic       glitch;
  } echo_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic tx;
  uart_echo_tester_if bus ();

  uart_echo_tester #(
    .DBIT(8), .SB_TICK(16), .DVSR(2), .TIMEOUT(2000)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int frames = 0;
  int run_base = 0;
  logic [2:0] mode = M_OK;
  bit mon_en = 1'b1;
  logic [7:0] sent_q[$];
  echo_t echo_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Receiver: decode each frame from tx, queue the echo reply.
  initial begin : mon
    logic [7:0] b;
    logic stop_v, st_ok, counting;
    int lows, idx;
    forever begin
      step();
      if (tx === 1'b0) begin
        lows = 1; counting = 1'b1; b = '0;
        st_ok = 1'b0; stop_v = 1'b0;
        for (int c = 1; c <= 304; c++) begin
          step();
          if (counting) begin
            if (tx === 1'b0) lows++;
            else counting = 1'b0;
          end
          if (c == 16) st_ok = (tx === 1'b0);
          if (c >= 48 && c <= 272 && ((c - 48) % 32) == 0)
            b[(c - 48) / 32] = tx;
          if (c == 304) stop_v = tx;
        end
        if (mon_en) begin
          idx = frames - run_base;
          if (sent_q.size() == 0) begin
            chk("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
          end else begin
            chk("tx_byte", {24'd0, b}, {24'd0, sent_q.pop_front()});
            chk("tx_start_mid", {31'd0, st_ok}, 32'd1);
            chk("tx_stop", {31'd0, stop_v}, 32'd1);
            if (b[0]) begin
              n_checks++;
              if (lows < 31 || lows > 32) begin
                n_fail++;
                $display("FAIL start_len act=%0d req=31..32", lows);
              end
            end
          end
          frames++;
          if (mode != M_SIL)
            echo_q.push_back('{
              d:      (mode == M_FIX) ? 8'h10 : b + INC,
              stopv:  !(mode == M_BAD && idx == 0),
              glitch: (mode == M_GL)});
        end
      end
    end
  end

  // Echo driver: serialize queued replies onto rx.
  initial begin : echo
    echo_t e;
    forever begin
      step();
      if (echo_q.size() != 0) begin
        e = echo_q.pop_front();
        repeat (40) step();
        if (e.glitch) begin
          rx = 1'b0;
          repeat (2) step();
          rx = 1'b1;
          repeat (30) step();
        end
        rx = 1'b0;
        repeat (32) step();
        for (int i = 0; i < 8; i++) begin
          rx = e.d[i];
          repeat (32) step();
        end
        rx = e.stopv;
        repeat (32) step();
        rx = 1'b1;
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic pulse(input logic [7:0] sd, input logic [7:0] cn);
    bus.start = 1'b1;
    bus.seed  = sd;
    bus.count = cn;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run(input logic [7:0] sd, input logic [7:0] cn);
    run_base = frames;
    for (int i = 0; i < int'(cn); i++) sent_q.push_back(sd + 8'(i));
    pulse(sd, cn);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    wait_done(3000 * int'(cn) + 200);
  endtask

  vec_t v[6];
  bit tx_hi;

  initial begin : main
    v[0] = '{M_OK,  8'h41, 8'd3, 8'd0, 1'b1, 8'h43, 8'h43 + INC};
    v[1] = '{M_OK,  8'hFE, 8'd3, 8'd0, 1'b1, 8'h00, 8'h00 + INC};
    v[2] = '{M_FIX, 8'h20, 8'd4, 8'd4, 1'b0, 8'h23, 8'h10};
    v[3] = '{M_SIL, 8'h55, 8'd2, 8'd2, 1'b0, 8'h56, 8'h00};
    v[4] = '{M_BAD, 8'h30, 8'd2, 8'd1, 1'b0, 8'h31, 8'h31 + INC};
    v[5] = '{M_GL,  8'h60, 8'd2, 8'd0, 1'b1, 8'h61, 8'h61 + INC};
    bus.start = 1'b0;
    bus.seed  = '0;
    bus.count = '0;
    repeat (3) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_pass", {31'd0, bus.pass}, 32'd0);
    chk("rst_err", {24'd0, bus.err_cnt}, 32'd0);
    chk("rst_ls", {24'd0, bus.last_sent}, 32'd0);
    chk("rst_lr", {24'd0, bus.last_rcvd}, 32'd0);
    reset = 1'b1;
    repeat (5) step();

    for (int k = 0; k < 6; k++) begin
      mode = v[k].mode;
      run(v[k].seed, v[k].cnt);
      chk($sformatf("v%0d_done", k), {31'd0, bus.done}, 32'd1);
      chk($sformatf("v%0d_busy", k), {31'd0, bus.busy}, 32'd0);
      chk($sformatf("v%0d_pass", k), {31'd0, bus.pass},
          {31'd0, v[k].pass});
      chk($sformatf("v%0d_err", k), {24'd0, bus.err_cnt},
          {24'd0, v[k].err});
      chk($sformatf("v%0d_ls", k), {24'd0, bus.last_sent},
          {24'd0, v[k].ls});
      chk($sformatf("v%0d_lr", k), {24'd0, bus.last_rcvd},
          {24'd0, v[k].lr});
      chk($sformatf("v%0d_frames", k), frames - run_base,
          {24'd0, v[k].cnt});
      repeat (60) step();
    end

    // count == 0: done one cycle after busy, tx stays idle.
    mode = M_OK;
    pulse(8'h99, 8'd0);
    chk("c0_busy", {31'd0, bus.busy}, 32'd1);
    chk("c0_done_low", {31'd0, bus.done}, 32'd0);
    tx_hi = (tx === 1'b1);
    step();
    chk("c0_done", {31'd0, bus.done}, 32'd1);
    chk("c0_busy_off", {31'd0, bus.busy}, 32'd0);
    chk("c0_pass", {31'd0, bus.pass}, 32'd1);
    chk("c0_err", {24'd0, bus.err_cnt}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (tx !== 1'b1) tx_hi = 1'b0;
      step();
    end
    chk("c0_tx_idle", {31'd0, tx_hi}, 32'd1);

    // Reset in the middle of the data bits.
    mode = M_SIL;
    mon_en = 1'b0;
    pulse(8'h5A, 8'd2);
    repeat (100) step();
    reset = 1'b0;
    step();
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_err", {24'd0, bus.err_cnt}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_ls", {24'd0, bus.last_sent}, 32'd0);
    reset = 1'b1;
    repeat (400) step();
    sent_q.delete();
    mode = M_OK;
    mon_en = 1'b1;

    // Fresh run after reset, with a stray start mid-run.
    run_base = frames;
    sent_q.push_back(8'h00);
    pulse(8'h00, 8'd1);
    chk("post_busy", {31'd0, bus.busy}, 32'd1);
    repeat (100) step();
    pulse(8'h80, 8'd5);
    wait_done(3300);
    chk("post_pass", {31'd0, bus.pass}, 32'd1);
    chk("post_err", {24'd0, bus.err_cnt}, 32'd0);
    chk("post_ls", {24'd0, bus.last_sent}, 32'd0);
    chk("post_lr", {24'd0, bus.last_rcvd}, {24'd0, INC});
    chk("post_frames", frames - run_base, 32'd1);
    repeat (400) step();
    chk("no_extra_frames", frames - run_base, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
